// File: rtl/ysyx_23060184_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter for a single shared memory port: latches the winner's request,
// holds it until accepted, and returns completion. Define YSYX_23060184_ARB_RR_EN for round-robin.
module ysyx_23060184_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    input  logic                lsu_req,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_we,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                ifu_grant,
    output logic                lsu_grant,
    output logic                ifu_done,
    output logic                lsu_done,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_valid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ready,
    input  logic                mem_done,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IFU = 2'd1,
        BUSY_LSU = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic                we_q,    we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                pick_lsu;

`ifdef YSYX_23060184_ARB_RR_EN
    // 1 = LSU won the most recent arbitration; on a tie the other requester wins.
    logic last_lsu_q, last_lsu_d;

    always_comb begin
        pick_lsu = lsu_req & (~ifu_req | ~last_lsu_q);
    end
`else
    always_comb begin
        pick_lsu = lsu_req;
    end
`endif

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
`ifdef YSYX_23060184_ARB_RR_EN
        last_lsu_d = last_lsu_q;
`endif
        case (state_q)
            IDLE: begin
                if (ifu_req || lsu_req) begin
                    valid_d = 1'b1;
`ifdef YSYX_23060184_ARB_RR_EN
                    last_lsu_d = pick_lsu;
`endif
                    if (pick_lsu) begin
                        state_d = BUSY_LSU;
                        addr_d  = lsu_addr;
                        we_d    = lsu_we;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                    end else begin
                        state_d = BUSY_IFU;
                        addr_d  = ifu_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            BUSY_IFU, BUSY_LSU: begin
                if (mem_ready) begin
                    valid_d = 1'b0;
                end
                // Completion may coincide with acceptance; write completions keep rdata.
                if (mem_done) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
`ifdef YSYX_23060184_ARB_RR_EN
            last_lsu_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
`ifdef YSYX_23060184_ARB_RR_EN
            last_lsu_q <= last_lsu_d;
`endif
        end
    end

    // Done pulses are masked by rst so a completion racing a reset is dropped.
    assign ifu_grant = (state_q == BUSY_IFU);
    assign lsu_grant = (state_q == BUSY_LSU);
    assign ifu_done  = (state_q == BUSY_IFU) & mem_done & ~rst;
    assign lsu_done  = (state_q == BUSY_LSU) & mem_done & ~rst;
    assign rdata     = rdata_q;
    assign mem_valid = valid_q;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// Bench for ysyx_23060184_mem_arbiter: scripted scenarios plus random traffic, with an
// expected-completion queue checked against owner, address and returned data.
module tb_ysyx_23060184_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req, lsu_req, lsu_we;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        ifu_grant, lsu_grant, ifu_done, lsu_done;
    logic [31:0] rdata;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready, mem_done;
    logic [31:0] mem_rdata;

    // Entry layout: {is_lsu, addr[31:0], rdata_after[31:0]}
    logic [64:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_rdata;
    logic        m_last_lsu;

    ysyx_23060184_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr),
        .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_we(lsu_we),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .ifu_grant(ifu_grant), .lsu_grant(lsu_grant),
        .ifu_done(ifu_done), .lsu_done(lsu_done), .rdata(rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        assert (!(ifu_grant && lsu_grant)) else $error("FAIL grant_overlap: ifu_grant=1 lsu_grant=1");
    end

    // Driver: memory responder. Raises mem_ready and mem_done together on the
    // (ready_dly+1)-th cycle of mem_valid and reports what it saw.
    task automatic mem_serve(input int ready_dly, input logic [31:0] rd, input logic perturb,
                             output logic [1:0] owner, output int nvalid, output logic stable,
                             output logic overlap, output logic [31:0] a, output logic we,
                             output logic [31:0] wd, output logic [3:0] wm, output int lat);
        logic found;
        owner = 2'b00; nvalid = 0; stable = 1'b1; overlap = 1'b0; lat = 0; found = 1'b0;
        a = '0; we = 1'b0; wd = '0; wm = '0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            lat = i + 1;
            if (ifu_grant && lsu_grant) overlap = 1'b1;
            if (perturb) begin
                lsu_addr  = $urandom;
                lsu_wdata = $urandom;
                lsu_wmask = 4'($urandom_range(0, 15));
            end
            if (mem_valid) begin
                if (nvalid == 0) begin
                    a = mem_addr; we = mem_we; wd = mem_wdata; wm = mem_wmask;
                end else if ({mem_addr, mem_we, mem_wdata, mem_wmask} !== {a, we, wd, wm}) begin
                    stable = 1'b0;
                end
                nvalid++;
                if (nvalid == ready_dly + 1) begin
                    mem_ready = 1'b1; mem_done = 1'b1; mem_rdata = rd;
                    #1;
                    owner = {lsu_done, ifu_done};
                    found = 1'b1;
                end
            end
        end
        if (found) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = $urandom;
    endtask

    task automatic idle_inputs();
        ifu_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0;
        ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        mem_ready = 1'b1; mem_done = 1'b1; mem_rdata = 32'h5555_AAAA;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ifu_grant, lsu_grant, ifu_done, lsu_done, mem_valid, mem_we} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {ifu_grant, lsu_grant, ifu_done, lsu_done, mem_valid, mem_we});
        end
        vectors++;
        if ({mem_addr, mem_wdata, mem_wmask, rdata} !== 100'b0) begin
            miscompares++;
            $display("FAIL reset_data: got addr=%h wdata=%h wmask=%h rdata=%h want all 0",
                     mem_addr, mem_wdata, mem_wmask, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ifu_done, lsu_done, mem_valid, rdata} !== 35'b0) begin
            miscompares++;
            $display("FAIL idle_ignores_done: got done=%b%b valid=%b rdata=%h want 0",
                     ifu_done, lsu_done, mem_valid, rdata);
        end
        idle_inputs();
        m_rdata = '0; m_last_lsu = 1'b0;
    endtask

    task automatic test_ifu_read();
        logic [1:0] owner; int nv, lat; logic st, ov, we; logic [31:0] a, wd; logic [3:0] wm;
        logic [64:0] ent;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
        lsu_we = 1'b1; lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 4'hF;
        exp_q.push_back({1'b0, 32'h8000_0000, 32'h0000_0413});
        mem_serve(0, 32'h0000_0413, 1'b0, owner, nv, st, ov, a, we, wd, wm, lat);
        ifu_req = 1'b0; m_last_lsu = 1'b0;
        ent = (exp_q.size() != 0) ? exp_q.pop_front() : 65'b0;
        m_rdata = ent[31:0];
        vectors++;
        if (owner !== {ent[64], ~ent[64]}) begin
            miscompares++; $display("FAIL ifu_owner: got %b want %b", owner, {ent[64], ~ent[64]});
        end
        vectors++;
        if ({lat, nv} !== {32'd1, 32'd1}) begin
            miscompares++; $display("FAIL ifu_latency: got lat=%0d valid_cycles=%0d want 1 1", lat, nv);
        end
        vectors++;
        if ({a, we, wd, wm} !== {ent[63:32], 1'b0, 32'h0, 4'h0}) begin
            miscompares++;
            $display("FAIL ifu_fields: got %h/%b/%h/%h want %h/0/0/0", a, we, wd, wm, ent[63:32]);
        end
        @(negedge clk);
        vectors++;
        if ({rdata, ifu_grant, mem_valid} !== {m_rdata, 2'b00}) begin
            miscompares++;
            $display("FAIL ifu_rdata: got rdata=%h grant=%b valid=%b want %h 0 0",
                     rdata, ifu_grant, mem_valid, m_rdata);
        end
    endtask

    task automatic test_lsu_write();
        logic [1:0] owner; int nv, lat; logic st, ov, we; logic [31:0] a, wd; logic [3:0] wm;
        logic [64:0] ent;
        lsu_req = 1'b1; lsu_addr = 32'h0200_0000; lsu_we = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        exp_q.push_back({1'b1, 32'h0200_0000, m_rdata});
        mem_serve(3, 32'hCAFE_0001, 1'b0, owner, nv, st, ov, a, we, wd, wm, lat);
        lsu_req = 1'b0; lsu_we = 1'b0; m_last_lsu = 1'b1;
        ent = (exp_q.size() != 0) ? exp_q.pop_front() : 65'b0;
        vectors++;
        if (owner !== 2'b10) begin
            miscompares++; $display("FAIL wr_owner: got %b want 10", owner);
        end
        vectors++;
        if ({nv, lat, st} !== {32'd4, 32'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL wr_valid_hold: got valid_cycles=%0d lat=%0d stable=%b want 4 4 1", nv, lat, st);
        end
        vectors++;
        if ({a, we, wd, wm} !== {ent[63:32], 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
            miscompares++;
            $display("FAIL wr_fields: got %h/%b/%h/%h want %h/1/deadbeef/f", a, we, wd, wm, ent[63:32]);
        end
        @(negedge clk);
        vectors++;
        if (rdata !== ent[31:0]) begin
            miscompares++; $display("FAIL wr_rdata_held: got %h want %h", rdata, ent[31:0]);
        end
    endtask

    task automatic test_priority();
        logic [1:0] owner; int nv, lat; logic st, ov, we; logic [31:0] a, wd; logic [3:0] wm;
        logic [64:0] ent;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_rdata = '0; m_last_lsu = 1'b0;
        for (int r = 0; r < 2; r++) begin
            ifu_req = 1'b1; ifu_addr = 32'h8000_0100 + 32'(r * 4);
            lsu_req = 1'b1; lsu_addr = 32'h3000_0000 + 32'(r * 8); lsu_we = 1'b0;
            // From a fresh reset both fixed and round-robin order give LSU then IFU.
            exp_q.push_back({1'b1, lsu_addr, 32'h1111_0000 + 32'(r)});
            exp_q.push_back({1'b0, ifu_addr, 32'h2222_0000 + 32'(r)});
            for (int k = 0; k < 2; k++) begin
                mem_serve(r, (k == 0) ? 32'h1111_0000 + 32'(r) : 32'h2222_0000 + 32'(r), 1'b0,
                          owner, nv, st, ov, a, we, wd, wm, lat);
                if (k == 0) lsu_req = 1'b0; else ifu_req = 1'b0;
                ent = (exp_q.size() != 0) ? exp_q.pop_front() : 65'b0;
                m_last_lsu = ent[64];
                vectors++;
                if ({owner, a} !== {ent[64], ~ent[64], ent[63:32]}) begin
                    miscompares++;
                    $display("FAIL prio_r%0d_k%0d: got owner=%b addr=%h want %b %h",
                             r, k, owner, a, {ent[64], ~ent[64]}, ent[63:32]);
                end
                @(negedge clk);
                vectors++;
                if (rdata !== ent[31:0]) begin
                    miscompares++; $display("FAIL prio_rdata_r%0d_k%0d: got %h want %h", r, k, rdata, ent[31:0]);
                end
                m_rdata = ent[31:0];
            end
        end
    endtask

    task automatic test_reset_mid();
        lsu_req = 1'b1; lsu_addr = 32'h1000_0004; lsu_we = 1'b0;
        @(negedge clk);
        vectors++;
        if ({lsu_grant, mem_valid, mem_addr} !== {2'b11, 32'h1000_0004}) begin
            miscompares++;
            $display("FAIL rstmid_busy: got grant=%b valid=%b addr=%h want 1 1 10000004",
                     lsu_grant, mem_valid, mem_addr);
        end
        lsu_req = 1'b0; rst = 1'b1; mem_done = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        vectors++;
        if ({ifu_done, lsu_done} !== 2'b00) begin
            miscompares++; $display("FAIL rstmid_done_in_rst: got %b%b want 00", ifu_done, lsu_done);
        end
        @(negedge clk);
        vectors++;
        if ({ifu_grant, lsu_grant, ifu_done, lsu_done, mem_valid, mem_we, mem_addr, rdata} !== 70'b0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got grants=%b%b done=%b%b valid=%b addr=%h rdata=%h want 0",
                     ifu_grant, lsu_grant, ifu_done, lsu_done, mem_valid, mem_addr, rdata);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({ifu_done, lsu_done, ifu_grant, lsu_grant, rdata} !== 36'b0) begin
                miscompares++;
                $display("FAIL rstmid_stray_done: got done=%b%b grants=%b%b rdata=%h want 0",
                         ifu_done, lsu_done, ifu_grant, lsu_grant, rdata);
            end
        end
        mem_done = 1'b0;
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++; $display("FAIL rstmid_queue: got %0d pending want 0", exp_q.size());
        end
        m_rdata = '0; m_last_lsu = 1'b0;
    endtask

    task automatic test_addr_change();
        logic [1:0] owner; int nv, lat; logic st, ov, we; logic [31:0] a, wd; logic [3:0] wm;
        logic [64:0] ent;
        lsu_req = 1'b1; lsu_addr = 32'h0F00_0040; lsu_we = 1'b1;
        lsu_wdata = 32'h1234_5678; lsu_wmask = 4'h3;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0200;
        exp_q.push_back({1'b1, 32'h0F00_0040, m_rdata});
        mem_serve(2, 32'hBEEF_0002, 1'b1, owner, nv, st, ov, a, we, wd, wm, lat);
        lsu_req = 1'b0; ifu_req = 1'b0;
        ent = (exp_q.size() != 0) ? exp_q.pop_front() : 65'b0;
        m_last_lsu = 1'b1;
        vectors++;
        if ({owner, st, ov, nv} !== {2'b10, 1'b1, 1'b0, 32'd3}) begin
            miscompares++;
            $display("FAIL chg_hold: got owner=%b stable=%b overlap=%b valid_cycles=%0d want 10 1 0 3",
                     owner, st, ov, nv);
        end
        vectors++;
        if ({a, wd, wm} !== {ent[63:32], 32'h1234_5678, 4'h3}) begin
            miscompares++;
            $display("FAIL chg_fields: got %h/%h/%h want %h/12345678/3", a, wd, wm, ent[63:32]);
        end
        @(negedge clk);
        vectors++;
        if (rdata !== ent[31:0]) begin
            miscompares++; $display("FAIL chg_rdata: got %h want %h", rdata, ent[31:0]);
        end
    endtask

    task automatic test_random();
        logic [1:0] owner; int nv, lat; logic st, ov, we; logic [31:0] a, wd; logic [3:0] wm;
        logic [64:0] ent;
        logic [1:0] r; logic win_lsu; int dly; logic [31:0] rd;
        for (int n = 0; n < 40; n++) begin
            r = 2'($urandom_range(1, 3));
            ifu_req = r[0]; lsu_req = r[1];
            ifu_addr = $urandom; lsu_addr = $urandom; lsu_we = 1'($urandom_range(0, 1));
            lsu_wdata = $urandom; lsu_wmask = 4'($urandom_range(0, 15));
            dly = $urandom_range(0, 3); rd = $urandom;
`ifdef YSYX_23060184_ARB_RR_EN
            win_lsu = lsu_req && (!ifu_req || !m_last_lsu);
`else
            win_lsu = lsu_req;
`endif
            exp_q.push_back({win_lsu, win_lsu ? lsu_addr : ifu_addr,
                             (win_lsu && lsu_we) ? m_rdata : rd});
            mem_serve(dly, rd, 1'b0, owner, nv, st, ov, a, we, wd, wm, lat);
            ifu_req = 1'b0; lsu_req = 1'b0;
            ent = (exp_q.size() != 0) ? exp_q.pop_front() : 65'b0;
            m_last_lsu = ent[64];
            vectors++;
            if ({owner, a, we, nv, lat, ov} !== {ent[64], ~ent[64], ent[63:32], ent[64] & lsu_we,
                                                  32'(dly + 1), 32'(dly + 1), 1'b0}) begin
                miscompares++;
                $display("FAIL rand_%0d: got owner=%b addr=%h we=%b valid=%0d lat=%0d ovl=%b want %b %h %b %0d %0d 0",
                         n, owner, a, we, nv, lat, ov, {ent[64], ~ent[64]}, ent[63:32],
                         ent[64] & lsu_we, dly + 1, dly + 1);
            end
            @(negedge clk);
            vectors++;
            if (rdata !== ent[31:0]) begin
                miscompares++; $display("FAIL rand_rdata_%0d: got %h want %h", n, rdata, ent[31:0]);
            end
            m_rdata = ent[31:0];
        end
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_priority();
        test_reset_mid();
        test_addr_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
